// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//   Shares one external word bus between an instruction-fetch port and a
//   data port. Each port owns a single pending slot; a three-state FSM
//   grants the bus to one slot at a time and returns the read word to the
//   requesting port one cycle after the bus completes.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   insn_start/insn_addr            fetch request pulse and word address
//   insn_flush                      drop pending fetch / squash in-flight fetch
//   insn_ready/insn_data_rd         fetch completion pulse and fetched word
//   data_start/data_addr            data request pulse and word address
//   data_write/data_data_wr/_be     write flag, write word, byte enables
//   data_ready/data_data_rd         data completion pulse and read word
//   bus_start/bus_addr/bus_write/
//   bus_data_wr/bus_data_be         registered external bus request
//   bus_ready/bus_data_rd           external bus completion and read word
//
// Parameter FAIR: 1 = alternate between ports on ties, 0 = data wins ties.

module core_bus_arbiter #(
    parameter bit FAIR = 1'b1,
    localparam int ADDR_W = 30,
    localparam int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              insn_start,
    input  logic [ADDR_W-1:0] insn_addr,
    input  logic              insn_flush,
    output logic              insn_ready,
    output logic [DATA_W-1:0] insn_data_rd,
    input  logic              data_start,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_write,
    input  logic [DATA_W-1:0] data_data_wr,
    input  logic [3:0]        data_data_be,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_data_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_start,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_data_wr,
    output logic [3:0]        bus_data_be,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_data_rd
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_INSN = 2'd1,
        BUSY_DATA = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Pending slots
    logic              insn_pend;
    logic [ADDR_W-1:0] insn_slot_addr;
    logic              data_pend;
    logic [ADDR_W-1:0] data_slot_addr;
    logic              data_slot_write;
    logic [DATA_W-1:0] data_slot_wr;
    logic [3:0]        data_slot_be;

    logic              last_grant_data;  // 0 = insn was granted last
    logic              flush_sup;        // in-flight fetch has been flushed

    logic              insn_acc, data_acc;
    logic              insn_eff, data_eff;
    logic [ADDR_W-1:0] insn_eff_addr;
    logic [ADDR_W-1:0] data_eff_addr;
    logic              data_eff_write;
    logic [DATA_W-1:0] data_eff_wr;
    logic [3:0]        data_eff_be;
    logic              grant_insn, grant_data;
    logic              insn_done, data_done;

    // A port's start is ignored while its own transaction is on the bus or
    // its slot is already occupied. A flush in the same cycle frees the insn
    // slot, so the new fetch replaces the cancelled one.
    assign insn_acc = insn_start && (state != BUSY_INSN) && (!insn_pend || insn_flush);
    assign data_acc = data_start && (state != BUSY_DATA) && !data_pend;

    // Slot view for this cycle's decision: an accepted start bypasses the
    // slot register so an idle bus is requested one cycle after start.
    assign insn_eff      = insn_acc || (insn_pend && !insn_flush);
    assign insn_eff_addr = insn_acc ? insn_addr : insn_slot_addr;
    assign data_eff       = data_acc || data_pend;
    assign data_eff_addr  = data_acc ? data_addr    : data_slot_addr;
    assign data_eff_write = data_acc ? data_write   : data_slot_write;
    assign data_eff_wr    = data_acc ? data_data_wr : data_slot_wr;
    assign data_eff_be    = data_acc ? data_data_be : data_slot_be;

    assign insn_done = (state == BUSY_INSN) && bus_ready;
    assign data_done = (state == BUSY_DATA) && bus_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_insn = 1'b0;
        grant_data = 1'b0;
        if ((state == IDLE) || insn_done || data_done) begin
            if (insn_eff && data_eff) begin
                if (FAIR && last_grant_data) begin
                    grant_insn = 1'b1;
                end else begin
                    grant_data = 1'b1;
                end
            end else if (insn_eff) begin
                grant_insn = 1'b1;
            end else if (data_eff) begin
                grant_data = 1'b1;
            end
            if (grant_insn) begin
                state_nxt = BUSY_INSN;
            end else if (grant_data) begin
                state_nxt = BUSY_DATA;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // Control: slot occupancy, fairness history, flush squash
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_pend       <= 1'b0;
            data_pend       <= 1'b0;
            last_grant_data <= 1'b0;
            flush_sup       <= 1'b0;
        end else begin
            insn_pend <= insn_eff && !grant_insn;
            data_pend <= data_eff && !grant_data;
            if (grant_insn) begin
                last_grant_data <= 1'b0;
            end else if (grant_data) begin
                last_grant_data <= 1'b1;
            end
            if (insn_done) begin
                flush_sup <= 1'b0;
            end else if ((state == BUSY_INSN) && insn_flush) begin
                flush_sup <= 1'b1;
            end
        end
    end

    // Slot payload: only meaningful while the matching pend bit is set
    always_ff @(posedge clk) begin
        if (insn_acc) begin
            insn_slot_addr <= insn_addr;
        end
        if (data_acc) begin
            data_slot_addr  <= data_addr;
            data_slot_write <= data_write;
            data_slot_wr    <= data_data_wr;
            data_slot_be    <= data_data_be;
        end
    end

    // Bus request and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_start    <= 1'b0;
            bus_addr     <= '0;
            bus_write    <= 1'b0;
            bus_data_wr  <= '0;
            bus_data_be  <= '0;
            insn_ready   <= 1'b0;
            data_ready   <= 1'b0;
            insn_data_rd <= '0;
            data_data_rd <= '0;
        end else begin
            bus_start <= grant_insn || grant_data;
            if (grant_insn) begin
                bus_addr    <= insn_eff_addr;
                bus_write   <= 1'b0;
                bus_data_wr <= '0;
                bus_data_be <= 4'b1111;
            end else if (grant_data) begin
                bus_addr    <= data_eff_addr;
                bus_write   <= data_eff_write;
                bus_data_wr <= data_eff_wr;
                bus_data_be <= data_eff_be;
            end
            // A flush arriving on the completion cycle squashes it as well
            insn_ready <= insn_done && !flush_sup && !insn_flush;
            data_ready <= data_done;
            if (insn_done && !flush_sup && !insn_flush) begin
                insn_data_rd <= bus_data_rd;
            end
            if (data_done) begin
                data_data_rd <= bus_data_rd;
            end
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter
//   Drives a FAIR=1 instance (u_fair, index 0) and a FAIR=0 instance
//   (u_nofair, index 1) with the same directed stimulus. A request-level
//   model tracks per-port pending requests, the bus owner and the last
//   winner, and every cycle the outputs of both instances are compared
//   against it; directed scenarios also check hand-computed literals.

module tb_core_bus_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        insn_start, insn_flush, data_start, data_write, bus_ready;
    logic [29:0] insn_addr, data_addr;
    logic [31:0] data_data_wr, bus_data_rd;
    logic [3:0]  data_data_be;

    logic        ir [2];
    logic [31:0] idr[2];
    logic        dr [2];
    logic [31:0] ddr[2];
    logic [29:0] ba [2];
    logic        bs [2];
    logic        bw [2];
    logic [31:0] bwd[2];
    logic [3:0]  bbe[2];

    core_bus_arbiter #(.FAIR(1'b1)) u_fair (
        .clk(clk), .rst_n(rst_n),
        .insn_start(insn_start), .insn_addr(insn_addr), .insn_flush(insn_flush),
        .insn_ready(ir[0]), .insn_data_rd(idr[0]),
        .data_start(data_start), .data_addr(data_addr), .data_write(data_write),
        .data_data_wr(data_data_wr), .data_data_be(data_data_be),
        .data_ready(dr[0]), .data_data_rd(ddr[0]),
        .bus_addr(ba[0]), .bus_start(bs[0]), .bus_write(bw[0]),
        .bus_data_wr(bwd[0]), .bus_data_be(bbe[0]),
        .bus_ready(bus_ready), .bus_data_rd(bus_data_rd)
    );

    core_bus_arbiter #(.FAIR(1'b0)) u_nofair (
        .clk(clk), .rst_n(rst_n),
        .insn_start(insn_start), .insn_addr(insn_addr), .insn_flush(insn_flush),
        .insn_ready(ir[1]), .insn_data_rd(idr[1]),
        .data_start(data_start), .data_addr(data_addr), .data_write(data_write),
        .data_data_wr(data_data_wr), .data_data_be(data_data_be),
        .data_ready(dr[1]), .data_data_rd(ddr[1]),
        .bus_addr(ba[1]), .bus_start(bs[1]), .bus_write(bw[1]),
        .bus_data_wr(bwd[1]), .bus_data_be(bbe[1]),
        .bus_ready(bus_ready), .bus_data_rd(bus_data_rd)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s[u%0d] t=%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Request-level model: owner 0 = bus free, 1 = insn, 2 = data
    bit          m_pi[2], m_pd[2], m_pdw[2], m_cancel[2];
    logic [29:0] m_pia[2], m_pda[2];
    logic [31:0] m_pdd[2];
    logic [3:0]  m_pdb[2];
    int          m_owner[2], m_last[2];

    logic        e_bs[2], e_bw[2], e_ir[2], e_dr[2];
    logic [29:0] e_ba[2];
    logic [31:0] e_bwd[2], e_idr[2], e_ddr[2];
    logic [3:0]  e_bbe[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pi[k] = 0; m_pd[k] = 0; m_cancel[k] = 0;
            m_owner[k] = 0; m_last[k] = 1;
            e_bs[k] = 0; e_bw[k] = 0; e_ir[k] = 0; e_dr[k] = 0;
            e_ba[k] = '0; e_bwd[k] = '0; e_idr[k] = '0; e_ddr[k] = '0; e_bbe[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int old;
            int pick;
            bit fair;
            old  = m_owner[k];
            fair = (k == 0);
            e_bs[k] = 0; e_ir[k] = 0; e_dr[k] = 0;
            // new requests
            if (insn_start && old != 1 && (!m_pi[k] || insn_flush)) begin
                m_pi[k] = 1; m_pia[k] = insn_addr;
            end else if (insn_flush) begin
                m_pi[k] = 0;
            end
            if (data_start && old != 2 && !m_pd[k]) begin
                m_pd[k] = 1; m_pda[k] = data_addr; m_pdw[k] = data_write;
                m_pdd[k] = data_data_wr; m_pdb[k] = data_data_be;
            end
            // completion
            if (old != 0 && bus_ready) begin
                if (old == 1) begin
                    if (!m_cancel[k] && !insn_flush) begin
                        e_ir[k] = 1; e_idr[k] = bus_data_rd;
                    end
                end else begin
                    e_dr[k] = 1; e_ddr[k] = bus_data_rd;
                end
                m_owner[k] = 0; m_cancel[k] = 0;
            end else if (old == 1 && insn_flush) begin
                m_cancel[k] = 1;
            end
            // arbitration
            if (m_owner[k] == 0) begin
                pick = 0;
                if (m_pi[k] && m_pd[k]) pick = (fair && m_last[k] == 2) ? 1 : 2;
                else if (m_pi[k])       pick = 1;
                else if (m_pd[k])       pick = 2;
                if (pick == 1) begin
                    m_pi[k] = 0;
                    e_ba[k] = m_pia[k]; e_bw[k] = 0; e_bwd[k] = '0; e_bbe[k] = 4'hF;
                end else if (pick == 2) begin
                    m_pd[k] = 0;
                    e_ba[k] = m_pda[k]; e_bw[k] = m_pdw[k]; e_bwd[k] = m_pdd[k]; e_bbe[k] = m_pdb[k];
                end
                if (pick != 0) begin
                    m_owner[k] = pick; m_last[k] = pick; e_bs[k] = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk(k, "cyc_bus_start",    bs[k],  e_bs[k]);
                chk(k, "cyc_bus_addr",     ba[k],  e_ba[k]);
                chk(k, "cyc_bus_write",    bw[k],  e_bw[k]);
                chk(k, "cyc_bus_data_wr",  bwd[k], e_bwd[k]);
                chk(k, "cyc_bus_data_be",  bbe[k], e_bbe[k]);
                chk(k, "cyc_insn_ready",   ir[k],  e_ir[k]);
                chk(k, "cyc_insn_data_rd", idr[k], e_idr[k]);
                chk(k, "cyc_data_ready",   dr[k],  e_dr[k]);
                chk(k, "cyc_data_data_rd", ddr[k], e_ddr[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        insn_start = 0; insn_flush = 0; data_start = 0; bus_ready = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(k, {tag, "_bus_start"},    bs[k],  0);
            chk(k, {tag, "_insn_ready"},   ir[k],  0);
            chk(k, {tag, "_data_ready"},   dr[k],  0);
            chk(k, {tag, "_bus_write"},    bw[k],  0);
            chk(k, {tag, "_bus_addr"},     ba[k],  0);
            chk(k, {tag, "_bus_data_wr"},  bwd[k], 0);
            chk(k, {tag, "_bus_data_be"},  bbe[k], 0);
            chk(k, {tag, "_insn_data_rd"}, idr[k], 0);
            chk(k, {tag, "_data_data_rd"}, ddr[k], 0);
        end
    endtask

    // Called one time unit after a rising edge; reset spans the mid-cycle
    task automatic do_reset(input string tag);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_reset_vals(tag);
        #2;
        rst_n = 1;
    endtask

    task automatic req_insn(input logic [29:0] a);
        insn_start = 1; insn_addr = a;
    endtask

    task automatic req_data(input logic [29:0] a, input logic w, input logic [31:0] d, input logic [3:0] be);
        data_start = 1; data_addr = a; data_write = w; data_data_wr = d; data_data_be = be;
    endtask

    task automatic complete(input logic [31:0] d);
        bus_ready = 1; bus_data_rd = d;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1;
        insn_start = 0; insn_flush = 0; data_start = 0; bus_ready = 0;
        insn_addr = '0; data_addr = '0; data_write = 0; data_data_wr = '0;
        data_data_be = '0; bus_data_rd = '0;
        #1;
        rst_n = 0;
        model_reset();
        #1;
        check_reset_vals("rst0");
        chk_en = 1;
        #1;
        rst_n = 1;

        // Single fetch: start cycle 0, bus_ready cycle 3
        req_insn(30'h100);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk(k, "s1_bus_start", bs[k], 1);
            chk(k, "s1_bus_addr",  ba[k], 32'h100);
            chk(k, "s1_bus_write", bw[k], 0);
            chk(k, "s1_bus_be",    bbe[k], 4'hF);
        end
        tick();
        tick();
        complete(32'hE3A00001);
        for (int k = 0; k < 2; k++) begin
            chk(k, "s1_insn_ready", ir[k],  1);
            chk(k, "s1_insn_data",  idr[k], 32'hE3A00001);
        end
        tick();
        chk(0, "s1_ready_drop", ir[0],  0);
        chk(0, "s1_data_hold",  idr[0], 32'hE3A00001);

        do_reset("rst1");

        // Tie 1: data first on both, insn issued with data_ready
        req_insn(30'h200); req_data(30'h300, 1, 32'hDEADBEEF, 4'b0011);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk(k, "t1_bus_addr",  ba[k],  32'h300);
            chk(k, "t1_bus_write", bw[k],  1);
            chk(k, "t1_bus_wr",    bwd[k], 32'hDEADBEEF);
            chk(k, "t1_bus_be",    bbe[k], 4'b0011);
        end
        tick();
        complete(32'h11111111);
        for (int k = 0; k < 2; k++) begin
            chk(k, "t1_data_ready", dr[k], 1);
            chk(k, "t1_data_rd",    ddr[k], 32'h11111111);
            chk(k, "t1_b2b_start",  bs[k], 1);
            chk(k, "t1_b2b_addr",   ba[k], 32'h200);
            chk(k, "t1_b2b_write",  bw[k], 0);
        end
        complete(32'h22222222);
        chk(0, "t1_insn_ready", ir[0], 1);

        // Tie 2: last grant was insn, data first again
        req_insn(30'h204); req_data(30'h304, 1, 32'hCAFEF00D, 4'b1100);
        tick();
        chk(0, "t2_bus_addr", ba[0], 32'h304);
        chk(1, "t2_bus_addr", ba[1], 32'h304);
        complete(32'h33333333);
        complete(32'h34343434);

        // Lone data request makes data the last winner
        req_data(30'h308, 0, 32'h0, 4'hF);
        tick();
        complete(32'h44444444);

        // Tie 3: fair picks insn, nofair keeps picking data
        req_insn(30'h20C); req_data(30'h30C, 1, 32'h0BADF00D, 4'hF);
        tick();
        chk(0, "t3_fair_addr",    ba[0], 32'h20C);
        chk(0, "t3_fair_write",   bw[0], 0);
        chk(1, "t3_nofair_addr",  ba[1], 32'h30C);
        chk(1, "t3_nofair_write", bw[1], 1);
        complete(32'h55555555);
        chk(0, "t3_fair_next",   ba[0], 32'h30C);
        chk(1, "t3_nofair_next", ba[1], 32'h20C);
        complete(32'h56565656);

        // Flush while insn in flight, data waits behind it
        req_insn(30'h400);
        tick();
        req_data(30'h500, 0, 32'h0, 4'hF);
        tick();
        insn_flush = 1;
        tick();
        complete(32'h66666666);
        for (int k = 0; k < 2; k++) begin
            chk(k, "fl_no_insn_ready", ir[k], 0);
            chk(k, "fl_data_start",    bs[k], 1);
            chk(k, "fl_data_addr",     ba[k], 32'h500);
        end
        complete(32'h77777777);
        chk(0, "fl_data_ready", dr[0], 1);

        // Pending-slot rules: duplicate ignored, flush+start keeps the new one
        req_data(30'h510, 0, 32'h0, 4'hF);
        tick();
        req_insn(30'h410);
        tick();
        req_insn(30'h414);
        tick();
        req_insn(30'h418); insn_flush = 1;
        tick();
        complete(32'h88888888);
        chk(0, "ps_restart_addr", ba[0], 32'h418);
        req_insn(30'h41C);
        tick();
        complete(32'h99999999);
        chk(0, "ps_inflight_ignored", bs[0], 0);
        chk(0, "ps_insn_ready",       ir[0], 1);
        req_insn(30'h420);
        tick();
        chk(0, "ps_same_cycle_start", bs[0], 1);
        chk(0, "ps_same_cycle_addr",  ba[0], 32'h420);
        complete(32'hAAAAAAAA);
        req_data(30'h520, 0, 32'h0, 4'hF);
        tick();
        req_insn(30'h424);
        tick();
        insn_flush = 1;
        tick();
        complete(32'hBBBBBBBB);
        chk(0, "ps_flushed_slot", bs[0], 0);
        tick();

        // Reset while a data transaction is on the bus
        req_data(30'h600, 1, 32'h12345678, 4'hF);
        tick();
        tick();
        do_reset("rst2");
        complete(32'hCCCCCCCC);
        for (int k = 0; k < 2; k++) begin
            chk(k, "rm_no_data_ready", dr[k], 0);
            chk(k, "rm_no_start",      bs[k], 0);
        end
        req_insn(30'h700);
        tick();
        chk(0, "rm_new_start", bs[0], 1);
        chk(0, "rm_new_addr",  ba[0], 32'h700);
        tick();
        complete(32'hDDDDDDDD);
        chk(0, "rm_insn_ready", ir[0],  1);
        chk(0, "rm_insn_data",  idr[0], 32'hDDDDDDDD);
        tick();
        tick();

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
